// File: rtl/time_set_controller.sv
// time_set_controller: manual time-setting sequencer for the clock.
// Walks the user through hours then minutes using two debounced buttons.
// It shows the edited field blinking and issues a one-cycle load pulse on commit.
// Optional feature macro: TIME_SET_AUTOREPEAT_EN. When it is defined, holding
// btn_inc auto-repeats increments.
module time_set_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned BLINK_HALF     = 12_500_000,
  parameter int unsigned REPEAT_DELAY   = 25_000_000,
  parameter int unsigned REPEAT_PERIOD  = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [6:0] minutes,
  input  logic [5:0] hours,
  output logic [6:0] minutes_settings,
  output logic [5:0] hours_settings,
  output logic       settings_signal,
  output logic       time_load,
  output logic       hours_vis,
  output logic       minutes_vis
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BL_W = $clog2(BLINK_HALF + 1);

  typedef enum logic [1:0] {IDLE, SET_H, SET_M, COMMIT} state_t;

  state_t          state_q, state_d;
  logic            mode_q, inc_q;
  logic [5:0]      hours_set_q, hours_set_d;
  logic [6:0]      mins_set_q, mins_set_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            phase_q, phase_d;
  logic            settings_q, settings_d;
  logic            load_q, load_d;
  logic            hvis_q, hvis_d;
  logic            mvis_q, mvis_d;

  logic mode_evt, inc_edge, inc_evt, rpt_evt, in_set;

  assign mode_evt = btn_mode & ~mode_q;
  assign inc_edge = btn_inc & ~inc_q;
  assign in_set   = (state_q == SET_H) || (state_q == SET_M);
  assign inc_evt  = inc_edge | rpt_evt;

`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q;
  logic             rpt_armed_q;
  logic             rpt_hit;

  // The first repeat waits REPEAT_DELAY; later repeats use REPEAT_PERIOD.
  always_comb begin
    rpt_hit = rpt_armed_q ? (rpt_cnt_q == RPT_W'(REPEAT_PERIOD - 1))
                          : (rpt_cnt_q == RPT_W'(REPEAT_DELAY - 1));
  end

  assign rpt_evt = in_set & btn_inc & inc_q & rpt_hit;

  // The hold counter restarts on each fresh press and clears on release or outside set states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
    end else if (!in_set || !btn_inc || inc_edge) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
    end else if (rpt_hit) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b1;
    end else begin
      rpt_cnt_q   <= rpt_cnt_q + 1'b1;
    end
  end
`else
  assign rpt_evt = 1'b0;
`endif

  // Next-state, edit, timeout, blink and output decode for the setting sequence.
  always_comb begin
    state_d     = state_q;
    hours_set_d = hours_set_q;
    mins_set_d  = mins_set_q;
    to_cnt_d    = to_cnt_q + 1'b1;
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;

    if (blink_cnt_q == BL_W'(BLINK_HALF - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end

    unique case (state_q)
      IDLE: begin
        if (mode_evt) begin
          hours_set_d = hours;
          mins_set_d  = minutes;
          state_d     = SET_H;
        end
      end
      SET_H: begin
        // A mode event wins over a simultaneous increment.
        if (mode_evt) begin
          state_d = SET_M;
        end else if (inc_evt) begin
          hours_set_d = (hours_set_q == 6'd23) ? 6'd0 : hours_set_q + 6'd1;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
        end
      end
      SET_M: begin
        if (mode_evt) begin
          state_d = COMMIT;
        end else if (inc_evt) begin
          mins_set_d = (mins_set_q == 7'd59) ? 7'd0 : mins_set_q + 7'd1;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
        end
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Activity or a state change restarts the inactivity timer.
    if (mode_evt || inc_evt || (state_d != state_q) || (state_q == IDLE)) begin
      to_cnt_d = '0;
    end
    // The edited field becomes visible at once on entry or after an increment.
    if ((state_d != state_q) || (in_set && inc_evt && !mode_evt) || (state_q == IDLE)) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end

    settings_d = (state_d != IDLE);
    load_d     = (state_d == COMMIT);
    hvis_d     = (state_d == SET_H) ? phase_d : 1'b1;
    mvis_d     = (state_d == SET_M) ? phase_d : 1'b1;
  end

  // Register the state, edge detectors, counters and all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      inc_q       <= 1'b0;
      hours_set_q <= '0;
      mins_set_q  <= '0;
      to_cnt_q    <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      settings_q  <= 1'b0;
      load_q      <= 1'b0;
      hvis_q      <= 1'b1;
      mvis_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      mode_q      <= btn_mode;
      inc_q       <= btn_inc;
      hours_set_q <= hours_set_d;
      mins_set_q  <= mins_set_d;
      to_cnt_q    <= to_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      settings_q  <= settings_d;
      load_q      <= load_d;
      hvis_q      <= hvis_d;
      mvis_q      <= mvis_d;
    end
  end

  assign minutes_settings = mins_set_q;
  assign hours_settings   = hours_set_q;
  assign settings_signal  = settings_q;
  assign time_load        = load_q;
  assign hours_vis        = hvis_q;
  assign minutes_vis      = mvis_q;

endmodule

// File: doc/time_set_controller.md
# time_set_controller

Sequences manual time setting for the clock. Walks the user through hours then minutes from two debounced push-buttons, and holds the edited values in `minutes_settings` / `hours_settings`. Drives `settings_signal` so the display mux shows the edited time while setting is in progress. On completion it issues a one-cycle load pulse so the timekeeping counter adopts the new time.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 500_000_000: idle cycles in a set state before aborting (10 s at 50 MHz).
- `BLINK_HALF`, 12_500_000: cycles per blink half-period of the field being edited.
- `REPEAT_DELAY`, 25_000_000: hold time before auto-repeat starts (used only with the macro).
- `REPEAT_PERIOD`, 5_000_000: cycles between auto-repeat steps (used only with the macro).

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `btn_mode`  in  1  debounced, synchronized level; rising edge advances the state.
- `btn_inc`  in  1  debounced, synchronized level; rising edge increments the selected field.
- `minutes`  in  7  live minutes from the timekeeper, 0..59.
- `hours`  in  6  live hours from the timekeeper, 0..23.
- `minutes_settings`  out  7  edited minutes.
- `hours_settings`  out  6  edited hours.
- `settings_signal`  out  1  1 selects the edited values on the display.
- `time_load`  out  1  one-cycle pulse; the timekeeper loads the `*_settings` values.
- `hours_vis`  out  1  display enable for the hours digits (blink).
- `minutes_vis`  out  1  display enable for the minutes digits (blink).

## Operation
- States: IDLE, SET_H, SET_M, COMMIT.
- Edge detection: registered previous level per button. `mode_evt = btn_mode & ~mode_q`; `inc_evt` is formed the same way.
- IDLE:
  - `settings_signal=0`; both vis outputs = 1.
  - On `mode_evt`: capture `hours`/`minutes` into the settings registers and go to SET_H.
- SET_H:
  - `inc_evt` → `hours_settings` +1, wrapping 23→0.
  - `mode_evt` → go to SET_M.
- SET_M:
  - `inc_evt` → `minutes_settings` +1, wrapping 59→0.
  - `mode_evt` → go to COMMIT.
- COMMIT: lasts exactly one cycle. `time_load=1`, `settings_signal=1`, then go to IDLE.
- `settings_signal=1` in SET_H, SET_M and COMMIT.
- Simultaneous `mode_evt` and `inc_evt`: the mode event wins and the increment is dropped.
- Timeout:
  - An inactivity counter clears on any event and on every state entry.
  - Reaching `TIMEOUT_CYCLES` in SET_H or SET_M → go to IDLE with no `time_load`. The settings registers keep their values.
- Blink:
  - A phase bit toggles every `BLINK_HALF` cycles.
  - The phase is forced to 1 (visible) and the blink counter cleared on state entry and on every increment.
  - SET_H: `hours_vis` = phase, `minutes_vis` = 1.
  - SET_M: `minutes_vis` = phase, `hours_vis` = 1.
  - COMMIT: both vis outputs = 1.
- Arithmetic:
  - Increments compare against 23/59 and load 0, not modulo 2^n.
  - Out-of-range captured inputs are not corrected.
- Reset values:
  - State IDLE.
  - `minutes_settings=0`, `hours_settings=0`, `settings_signal=0`, `time_load=0`.
  - `hours_vis=1`, `minutes_vis=1`.
  - Edge registers 0, all counters 0.
- Reset mid-set: immediate IDLE, no load pulse.

## Timing
- Button high first sampled at edge k → event at edge k. The state change or increment is visible after edge k.
- Holding a button produces no further events without the macro.
- Capture happens at the IDLE→SET_H edge; `settings_signal` rises at that same edge.
- Third `mode_evt` at edge k → COMMIT after edge k. `time_load` is high for the cycle from edge k to k+1, then IDLE.
- Timeout fires on the `TIMEOUT_CYCLES`-th consecutive event-free cycle after entry.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `TIME_SET_AUTOREPEAT_EN` defined:
  - In SET_H/SET_M, `btn_inc` held continuously for `REPEAT_DELAY` cycles after its edge produces an extra `inc_evt`.
  - Further extra events follow every `REPEAT_PERIOD` cycles while the button stays held.
  - Repeat events reset the timeout counter and the blink phase.
  - Releasing the button clears the repeat counter.
- Undefined: only rising edges increment; the repeat logic and its parameters are unused.

## Test plan
Use small parameters for all scenarios: TIMEOUT_CYCLES=40, BLINK_HALF=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
- Full set flow:
  - Stimulus: live 10:25; mode; inc ×3; mode; inc ×2; mode.
  - Required: `time_load` pulses once with 13:27, `settings_signal` falls the cycle after the pulse.
- Wraparound:
  - Stimulus: capture 23:59; inc in SET_H; inc in SET_M.
  - Required: hours 0, minutes 0.
- Collision and hold:
  - Stimulus: `btn_mode` and `btn_inc` rise on the same edge in SET_H.
  - Required: go to SET_M, `hours_settings` unchanged.
  - Stimulus: hold `btn_inc` 20 cycles without the macro.
  - Required: exactly one increment.
- Timeout:
  - Stimulus: enter SET_M and wait 40 cycles idle.
  - Required: IDLE, `settings_signal=0`, no `time_load`.
- Reset mid-set:
  - Stimulus: assert `rst_n` low between edges in SET_H.
  - Required: outputs go immediately to reset values; no load pulse after release.
- Blink and auto-repeat:
  - Blink: in SET_H, `hours_vis` toggles every 4 cycles and returns to 1 on inc.
  - Auto-repeat (with `TIME_SET_AUTOREPEAT_EN`): hold inc 20 cycles in SET_M starting from 0. Required: minutes = 1 + 1 at cycle 8 + repeats at 11, 14, 17, 20 = 6.
